alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one 32-bit ALU instance (module ALU, 4-bit ALUControl encoding) between two requesters, e.g. the integer pipe and an address/microcode sequencer.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin or fixed priority. Operands and op are registered. The ALU result is captured and held until the owning requester accepts it.
- Also keeps a completed-operation counter for performance monitoring.

Parameters:
- ARB_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (requester 0 wins).
- RR_INIT, 0, requester favoured first after reset in round-robin mode.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle when valid&ready
- req0_a  in  32  operand A
- req0_b  in  32  operand B
- req0_op  in  4  ALUControl code
- rsp0_valid  out  1  result for requester 0 available
- rsp0_ready  in  1  requester 0 takes result
- rsp0_data  out  32  result
- rsp0_err  out  1  illegal op flag (see Optional Feature)
- req1_*/rsp1_*  same set for requester 1
- ops_done  out  CNT_W  count of completed response handshakes
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All state changes on the rising edge of clk.
- Reset values: state = IDLE, all ready/valid outputs 0, rsp*_data = 0, rsp*_err = 0, ops_done = 0, busy = 0, rr_ptr = RR_INIT, operand/op/owner registers = 0.
- States:
  - IDLE: grant logic active.
  - EXEC: ALU driven from registered a/b/op; alu_out captured into result register at end of cycle.
  - RESP: rsp_valid of owner high until handshake.
- Grant (IDLE only, combinational):
  - Only one reqN_ready may be high.
  - Round-robin: if both valid, grant rr_ptr; else grant whichever is valid.
  - Fixed priority: req0 wins whenever valid.
  - reqN_ready = 0 in EXEC and RESP, and in IDLE for the non-granted requester.
  - ready may depend on valid; valid must not depend on ready.
- Accept (edge where reqN_valid & reqN_ready):
  - latch a, b, op, owner = N; go to EXEC.
  - Round-robin: rr_ptr <= ~N, updated on accept only.
- EXEC always lasts exactly one cycle, then RESP.
- RESP:
  - rspOwner_valid = 1, rspOwner_data = captured result.
  - Other requester's rsp_valid = 0.
  - Data and err are held stable while valid & !ready.
  - On rspOwner_ready: go to IDLE; valid drops next cycle; ops_done += 1 (wraps modulo 2^CNT_W).
- Latency:
  - Accept at edge N → rsp_valid high from cycle N+2.
  - Minimum 3 cycles between accepts, since the next accept can happen only after the state has returned to IDLE.
- rsp_ready asserted while rsp_valid = 0 is ignored. Request inputs are ignored outside IDLE.
- Arithmetic: exactly per ALU encoding.
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU, 1010 MUL (low 32 bits).
  - Shifts use B[4:0]. Undefined codes yield 0.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded with no response, and all reset values are applied.

Optional Feature:
- Macro: ALU_SHARE_ILLEGAL_OP_EN
- Defined:
  - Ops 1011–1111 are flagged at accept.
  - The response carries rspN_err = 1, rspN_data = 0 with normal latency.
  - The ALU is still sequenced, but its result is discarded.
  - ops_done still increments.
- Undefined:
  - rspN_err is tied to 0.
  - Illegal codes return ALU default output 0 with no flag.

Test Plan:
- Single ADD: req0 a=5, b=7, op=0000, rsp0_ready=1 → accept at edge N; rsp0_valid=1 and rsp0_data=12 in cycle N+2; ops_done=1.
- SUB/SRA: req1 a=3, b=5, op=0001 → 0xFFFFFFFE. Then a=0x80000000, b=4, op=0111 → 0xF8000000.
- Contention, ARB_MODE=0, RR_INIT=0: both valid continuously, each issuing ADD a=i b=0 → grant order 0,1,0,1; each response goes only to the owner's rsp port.
- Fixed priority, ARB_MODE=1: both valid for 4 ops → req0 granted all 4, req1_ready stays 0 throughout.
- Backpressure: MUL a=0x10000, b=0x10000 with rsp0_ready=0 for 3 cycles → rsp0_valid held, rsp0_data=0 stable, no new grant (req1 valid ignored), busy=1; ops_done increments only after rsp0_ready=1.
- Reset in EXEC: pulse rst during EXEC → next cycle state IDLE, no rsp_valid ever asserted for that op, ops_done=0. With ALU_SHARE_ILLEGAL_OP_EN, op=1100 → rsp_err=1, rsp_data=0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Shares one 32-bit ALU between two valid/ready requesters (round-robin or fixed priority).
// Latency: accept at edge N, response valid from cycle N+2; one op in flight, next accept >= 3 cycles later.
// Backpressure: result held in RESP until the owner's rsp_ready; no new grants until then.
// Optional: define ALU_SHARE_ILLEGAL_OP_EN to flag ALU codes 1011-1111 with rsp_err and zero data.
module alu_share_arbiter #(
  parameter int ARB_MODE = 0,  // 0 = round-robin, 1 = fixed priority (requester 0 wins)
  parameter int RR_INIT  = 0,  // requester favoured first after reset in round-robin mode
  parameter int CNT_W    = 16  // completed-operation counter width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [3:0]       req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_data,
  output logic             rsp0_err,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [3:0]       req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_data,
  output logic             rsp1_err,
  output logic [CNT_W-1:0] ops_done,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic        rr_ptr;      // requester favoured on contention (round-robin only)
  logic        owner;       // requester that owns the in-flight op
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [3:0]  op_q;
  logic        err_q;       // in-flight op was flagged illegal at accept
  logic [31:0] result_q;
  logic [31:0] alu_out;
  logic        gnt0;
  logic        gnt1;
  logic        acc0;
  logic        acc1;
  logic        illegal_in;
  logic        rsp_hs;

  // Grant decision: only while IDLE, never both requesters at once
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      if (ARB_MODE == 1) begin
        gnt0 = req0_valid;
        gnt1 = req1_valid & ~req0_valid;
      end else if (req0_valid & req1_valid) begin
        gnt0 = ~rr_ptr;
        gnt1 = rr_ptr;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign acc0       = req0_valid & gnt0;
  assign acc1       = req1_valid & gnt1;

`ifdef ALU_SHARE_ILLEGAL_OP_EN
  // Codes above MUL (1010) have no defined operation
  assign illegal_in = acc1 ? (req1_op > 4'd10) : (req0_op > 4'd10);
`else
  assign illegal_in = 1'b0;
`endif

  // Shared ALU, driven only from the registered operands
  always_comb begin
    alu_out = 32'd0;
    case (op_q)
      4'b0000: alu_out = a_q + b_q;
      4'b0001: alu_out = a_q - b_q;
      4'b0010: alu_out = a_q & b_q;
      4'b0011: alu_out = a_q | b_q;
      4'b0100: alu_out = a_q ^ b_q;
      4'b0101: alu_out = a_q << b_q[4:0];
      4'b0110: alu_out = a_q >> b_q[4:0];
      4'b0111: alu_out = $signed(a_q) >>> b_q[4:0];
      4'b1000: alu_out = {31'd0, $signed(a_q) < $signed(b_q)};
      4'b1001: alu_out = {31'd0, a_q < b_q};
      4'b1010: alu_out = a_q * b_q;  // low 32 bits of the product
      default: alu_out = 32'd0;
    endcase
  end

  // Control FSM with operand capture, result capture and round-robin pointer update
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= (RR_INIT != 0);
      owner    <= 1'b0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      op_q     <= 4'd0;
      err_q    <= 1'b0;
      result_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (acc0 | acc1) begin
            owner <= acc1;
            a_q   <= acc1 ? req1_a  : req0_a;
            b_q   <= acc1 ? req1_b  : req0_b;
            op_q  <= acc1 ? req1_op : req0_op;
            err_q <= illegal_in;
            state <= EXEC;
            if (ARB_MODE == 0) begin
              rr_ptr <= ~acc1;
            end
          end
        end
        EXEC: begin
          // Illegal ops still pass through the ALU; their result is dropped here
          result_q <= err_q ? 32'd0 : alu_out;
          state    <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp0_valid = (state == RESP) & ~owner;
  assign rsp1_valid = (state == RESP) & owner;
  assign rsp0_data  = rsp0_valid ? result_q : 32'd0;
  assign rsp1_data  = rsp1_valid ? result_q : 32'd0;
  assign rsp0_err   = rsp0_valid & err_q;
  assign rsp1_err   = rsp1_valid & err_q;
  assign rsp_hs     = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
  assign busy       = (state != IDLE);

  // Completed-response counter, wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      ops_done <= '0;
    end else if (rsp_hs) begin
      ops_done <= ops_done + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: one round-robin and one fixed-priority instance share a driver.
// The driver issues directed then random ops and pushes expected responses; a monitor checks them.
// A reset is pulsed while an op is in EXEC; the discarded op must never respond.
module tb_alu_share_arbiter;

  typedef struct {
    int          owner;
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rq_v   [2][2];
  logic        rq_r   [2][2];
  logic [31:0] rq_a   [2][2];
  logic [31:0] rq_b   [2][2];
  logic [3:0]  rq_op  [2][2];
  logic        rs_v   [2][2];
  logic        rs_r   [2][2];
  logic [31:0] rs_d   [2][2];
  logic        rs_err [2][2];
  logic [15:0] ops    [2];
  logic        bsy    [2];

  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   exp_gnt [2];
  int   acc_cyc [2];
  int   hs_cyc  [2];
  int   m_ops   [2];
  bit   seen    [2];
  bit   post_rst;
  int   m_ptr;
  exp_t sbq [2][$];
  logic [31:0] pexp [2][2];
  logic        perr [2][2];

  // Directed ops with hand-computed results
  int          d_n  [9] = '{0, 1, 1, 0, 0, 1, 0, 1, 0};
  logic [31:0] d_a  [9] = '{32'd5, 32'd3, 32'h80000000, 32'h00010000, 32'd1,
                            32'hFFFFFFFF, 32'd1, 32'hF0000000, 32'hFFFFFFFF};
  logic [31:0] d_b  [9] = '{32'd7, 32'd5, 32'd4, 32'h00010000, 32'd2, 32'd1, 32'd31, 32'd4, 32'd1};
  logic [3:0]  d_op [9] = '{4'd0, 4'd1, 4'd7, 4'd10, 4'd12, 4'd8, 4'd5, 4'd6, 4'd9};
  logic [31:0] d_e  [9] = '{32'd12, 32'hFFFFFFFE, 32'hF8000000, 32'd0, 32'd0,
                            32'd1, 32'h80000000, 32'h0F000000, 32'd0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_share_arbiter #(.ARB_MODE(g), .RR_INIT(0), .CNT_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (rq_v[g][0]),
      .req0_ready (rq_r[g][0]),
      .req0_a     (rq_a[g][0]),
      .req0_b     (rq_b[g][0]),
      .req0_op    (rq_op[g][0]),
      .rsp0_valid (rs_v[g][0]),
      .rsp0_ready (rs_r[g][0]),
      .rsp0_data  (rs_d[g][0]),
      .rsp0_err   (rs_err[g][0]),
      .req1_valid (rq_v[g][1]),
      .req1_ready (rq_r[g][1]),
      .req1_a     (rq_a[g][1]),
      .req1_b     (rq_b[g][1]),
      .req1_op    (rq_op[g][1]),
      .rsp1_valid (rs_v[g][1]),
      .rsp1_ready (rs_r[g][1]),
      .rsp1_data  (rs_d[g][1]),
      .rsp1_err   (rs_err[g][1]),
      .ops_done   (ops[g]),
      .busy       (bsy[g])
    );
  end

  // Reference ALU from the encoding table, using plain arithmetic
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    logic [63:0] p;
    logic [4:0]  sh;
    sh = b[4:0];
    p  = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return (a >> sh) | (a[31] ? ~(32'hFFFFFFFF >> sh) : 32'd0);
      4'd8:  return ((a ^ 32'h80000000) < (b ^ 32'h80000000)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return p[31:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_err(input logic [3:0] op);
`ifdef ALU_SHARE_ILLEGAL_OP_EN
    return op >= 4'd11;
`else
    return 1'b0;
`endif
  endfunction

  // Arbiter can accept in cycle c when the last release follows the last accept
  function automatic bit mfree(input int g, input int c);
    return (hs_cyc[g] >= acc_cyc[g]) && (c > hs_cyc[g]);
  endfunction

  task automatic chk(input int g, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL [arb_mode=%0d] %s at cycle %0d: got 0x%08h expected 0x%08h",
                  g, name, cyc, act, exp);
  endtask

  // Driver: stimulus plus expected grant / response prediction
  initial begin
    int   gnt_prev [2];
    int   last0;
    int   dir_idx;
    int   c;
    int   gr;
    bit   arm;
    bit   idle;
    exp_t e;
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      exp_gnt[g]  = -1;
      acc_cyc[g]  = -2;
      gnt_prev[g] = -1;
      for (int n = 0; n < 2; n++) begin
        rq_v[g][n] = 1'b0; rq_a[g][n] = 32'd0; rq_b[g][n] = 32'd0; rq_op[g][n] = 4'd0;
        rs_r[g][n] = 1'b0; pexp[g][n] = 32'd0; perr[g][n] = 1'b0;
      end
    end
    m_ptr = 0; dir_idx = 0; arm = 1'b0;
    repeat (2) @(posedge clk);
    for (int step = 0; step < 4000; step++) begin
      @(posedge clk); #1;
      c     = cyc;
      rst   = 1'b0;
      last0 = gnt_prev[0];
      for (int g = 0; g < 2; g++) begin
        if (gnt_prev[g] >= 0) rq_v[g][gnt_prev[g]] = 1'b0;
        gnt_prev[g] = -1;
        for (int n = 0; n < 2; n++) rs_r[g][n] = ($urandom_range(0, 9) < 6);
      end
      if (step == 1500 || step == 2800) arm = 1'b1;
      if (arm && last0 >= 0) begin
        // Instance 0 is in EXEC now: reset both instances for exactly one cycle
        arm = 1'b0;
        rst = 1'b1;
        m_ptr = 0;
        for (int g = 0; g < 2; g++) begin
          exp_gnt[g] = -1;
          for (int n = 0; n < 2; n++) rq_v[g][n] = 1'b0;
        end
        continue;
      end
      if (dir_idx < 9) begin
        idle = 1'b1;
        for (int g = 0; g < 2; g++)
          if (rq_v[g][0] || rq_v[g][1] || sbq[g].size() != 0 || !mfree(g, c)) idle = 1'b0;
        if (idle) begin
          for (int g = 0; g < 2; g++) begin
            rq_v[g][d_n[dir_idx]]  = 1'b1;
            rq_a[g][d_n[dir_idx]]  = d_a[dir_idx];
            rq_b[g][d_n[dir_idx]]  = d_b[dir_idx];
            rq_op[g][d_n[dir_idx]] = d_op[dir_idx];
            pexp[g][d_n[dir_idx]]  = d_e[dir_idx];
            perr[g][d_n[dir_idx]]  = exp_err(d_op[dir_idx]);
          end
          dir_idx++;
        end
      end else begin
        for (int g = 0; g < 2; g++)
          for (int n = 0; n < 2; n++)
            if (!rq_v[g][n] && $urandom_range(0, 2) != 0) begin
              rq_v[g][n]  = 1'b1;
              rq_a[g][n]  = $urandom;
              rq_b[g][n]  = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 40);
              rq_op[g][n] = 4'($urandom_range(0, 15));
              perr[g][n]  = exp_err(rq_op[g][n]);
              pexp[g][n]  = perr[g][n] ? 32'd0 : alu_ref(rq_a[g][n], rq_b[g][n], rq_op[g][n]);
            end
      end
      for (int g = 0; g < 2; g++) begin
        gr = -1;
        if (mfree(g, c)) begin
          if (g == 1)                          gr = rq_v[g][0] ? 0 : (rq_v[g][1] ? 1 : -1);
          else if (rq_v[g][0] && rq_v[g][1])   gr = m_ptr;
          else                                 gr = rq_v[g][0] ? 0 : (rq_v[g][1] ? 1 : -1);
        end
        exp_gnt[g]  = gr;
        gnt_prev[g] = gr;
        if (gr >= 0) begin
          e.owner = gr; e.data = pexp[g][gr]; e.err = perr[g][gr]; e.due = c + 2;
          sbq[g].push_back(e);
          acc_cyc[g] = c;
          if (g == 0) m_ptr = 1 - gr;
        end
      end
    end
    // Drain: stop issuing, accept every remaining response
    @(posedge clk); #1;
    for (int g = 0; g < 2; g++) begin
      exp_gnt[g] = -1;
      for (int n = 0; n < 2; n++) begin rq_v[g][n] = 1'b0; rs_r[g][n] = 1'b1; end
    end
    repeat (10) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Monitor: compares grants, busy and responses against the scoreboard
  initial begin
    exp_t e;
    for (int g = 0; g < 2; g++) begin hs_cyc[g] = -1; m_ops[g] = 0; seen[g] = 1'b0; end
    post_rst = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int g = 0; g < 2; g++) begin
          sbq[g].delete();
          hs_cyc[g] = cyc; m_ops[g] = 0; seen[g] = 1'b0;
        end
        post_rst = 1'b1;
      end else begin
        for (int g = 0; g < 2; g++) begin
          if (post_rst) begin
            chk(g, "reset_ops_done", 32'(ops[g]), 32'd0);
            chk(g, "reset_busy", 32'(bsy[g]), 32'd0);
            for (int n = 0; n < 2; n++) begin
              chk(g, "reset_rsp_valid", 32'(rs_v[g][n]), 32'd0);
              chk(g, "reset_rsp_data", rs_d[g][n], 32'd0);
              chk(g, "reset_rsp_err", 32'(rs_err[g][n]), 32'd0);
            end
          end
          chk(g, "req0_ready", 32'(rq_r[g][0]), 32'(exp_gnt[g] == 0));
          chk(g, "req1_ready", 32'(rq_r[g][1]), 32'(exp_gnt[g] == 1));
          chk(g, "busy", 32'(bsy[g]),
              32'(acc_cyc[g] < cyc && (hs_cyc[g] < acc_cyc[g] || cyc <= hs_cyc[g])));
          if (sbq[g].size() > 0 && cyc == sbq[g][0].due)
            chk(g, "rsp_valid_on_time", 32'(rs_v[g][sbq[g][0].owner]), 32'd1);
          for (int n = 0; n < 2; n++) begin
            if (rs_v[g][n]) begin
              if (sbq[g].size() == 0 || sbq[g][0].owner != n) begin
                chk(g, n == 0 ? "rsp0_valid_unexpected" : "rsp1_valid_unexpected",
                    32'(rs_v[g][n]), 32'd0);
              end else begin
                if (!seen[g]) begin
                  chk(g, "rsp_latency_cycle", cyc, sbq[g][0].due);
                  seen[g] = 1'b1;
                end
                chk(g, "rsp_data", rs_d[g][n], sbq[g][0].data);
                chk(g, "rsp_err", 32'(rs_err[g][n]), 32'(sbq[g][0].err));
                if (rs_r[g][n]) begin
                  chk(g, "ops_done", 32'(ops[g]), 32'(m_ops[g] & 32'hFFFF));
                  e = sbq[g].pop_front();
                  m_ops[g]++;
                  hs_cyc[g] = cyc;
                  seen[g]   = 1'b0;
                end
              end
            end
          end
        end
        post_rst = 1'b0;
      end
    end
  end

endmodule
